// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered output stage and status flags.
// Defining ALU_PIPE_MUL_EN adds an iterative radix-2 shift-add multiplier
// (op 1100) that holds the block BUSY for WIDTH cycles. Without it, 1100 is
// an unassigned op and the FSM never leaves IDLE.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             carry_flag,
    output logic             ovf_flag
);

    localparam int unsigned W1 = WIDTH + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic             accept;
    logic             start_mul;
    logic             mul_last;
    logic [WIDTH-1:0] mul_res;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [W1-1:0]    sum_add;
    logic [W1-1:0]    sum_sub;
    logic [SHW-1:0]   shamt;

    // Accept only when idle and the output slot is free or being drained.
    assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
    localparam logic [3:0]  OP_MUL = 4'b1100;
    localparam int unsigned CW     = SHW + 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;

    assign start_mul = (alu_control == OP_MUL);
    assign mul_last  = (cnt == CW'(1));
    assign mul_res   = acc + (mplier[0] ? mcand : '0);

    // Shift-add multiplier: latch operands on accept, one partial product per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (state == IDLE && accept && start_mul) begin
            cnt    <= CW'(WIDTH);
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (state == BUSY) begin
            acc    <= mul_res;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
        end
    end
`else
    assign start_mul = 1'b0;
    assign mul_last  = 1'b1;
    assign mul_res   = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a MUL accept enters BUSY, the last multiply step returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && start_mul) state_next = BUSY;
            BUSY:    if (mul_last)            state_next = IDLE;
            default:                          state_next = IDLE;
        endcase
    end

    // Single-cycle operations and their carry/overflow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} + {1'b0, ~b} + W1'(1);
        case (alu_control)
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sum_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Output register: load on single-cycle accept or MUL completion, clear valid on consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            result     <= '0;
            zero_flag  <= 1'b0;
            neg_flag   <= 1'b0;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else if (accept && !start_mul) begin
            out_valid  <= 1'b1;
            result     <= alu_res;
            zero_flag  <= (alu_res == '0);
            neg_flag   <= alu_res[WIDTH-1];
            carry_flag <= alu_c;
            ovf_flag   <= alu_v;
        end else if (state == BUSY && mul_last) begin
            out_valid  <= 1'b1;
            result     <= mul_res;
            zero_flag  <= (mul_res == '0);
            neg_flag   <= mul_res[WIDTH-1];
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor of the combinational datapath ALU. Executes one operation per transaction on `WIDTH`-bit operands through a registered output stage, with valid/ready flow control on input and output. Adds signed compare, shifts, full status flags and an optional iterative multiplier. Sits between the register-read stage and writeback, stalling the datapath through `in_ready` while a multi-cycle operation runs.

## Interface
- `WIDTH`, 32: operand/result width, ≥ 4, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and op are valid.
- `in_ready`  out  1  block accepts a transaction this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B (shift amount = `b[SHW-1:0]`).
- `alu_control`  in  4  operation select.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes result this cycle.
- `result`  out  WIDTH  registered result.
- `zero_flag`, `neg_flag`, `carry_flag`, `ovf_flag`  out  1 each  registered status.

## Operation
- Encoding: 0001 ADD, 0010 SUB, 0011 SLTU (unsigned a<b → 1 else 0), 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1000 SLT (signed), 1001 SLL, 1010 SRL, 1011 SRA, 1100 MUL (low WIDTH bits of a·b), all others → result 0.
- Transfer on input when `in_valid && in_ready`; on output when `out_valid && out_ready`.
- `in_ready = !reset && state==IDLE && (!out_valid || out_ready)`.
- FSM: IDLE → (accept MUL) → BUSY → (counter reaches 0) → IDLE. All non-MUL ops stay in IDLE.
- MUL: radix-2 shift-add; latches a, b; counter loads `WIDTH`; each BUSY cycle adds shifted multiplicand when current multiplier LSB is 1, decrements counter.
- Flags computed from the final result: `zero_flag` = result==0; `neg_flag` = result[WIDTH-1].
- ADD: `carry_flag` = carry out of bit WIDTH-1; `ovf_flag` = signed overflow (operands same sign, result differs).
- SUB: computed as a + ~b + 1; `carry_flag` = 1 when no borrow (a ≥ b unsigned); `ovf_flag` = signed overflow (operands differ in sign, result sign ≠ a sign).
- All other ops: `carry_flag` = `ovf_flag` = 0.
- Shift amounts ≥ WIDTH impossible by width; shift by 0 returns a.
- Output register holds value and flags until consumed; never overwritten while `out_valid && !out_ready`.

## Timing
- Reset: state IDLE, `out_valid`=0, `result`=0, all flags 0, counter 0; `in_ready`=0 while `reset` high.
- Single-cycle ops: accepted at edge N → `out_valid`=1 after edge N, i.e. one-cycle latency; throughput one per cycle while `out_ready`=1.
- MUL: accepted at edge N → BUSY for WIDTH cycles → `out_valid`=1 after edge N+WIDTH; `in_ready`=0 throughout BUSY.
- Output consumed and new op accepted on same edge: register reloads, `out_valid` stays 1.
- `out_ready`=1 with `out_valid`=0 is ignored.
- Reset during BUSY: aborts MUL, no result produced, IDLE next cycle.
- Inputs sampled only at acceptance; changes while BUSY have no effect.

## Configuration
- `ALU_PIPE_MUL_EN` defined: MUL datapath, counter and BUSY state present as above.
- Undefined: no multiplier logic; 1100 treated as unassigned (result 0, `zero_flag`=1, one-cycle latency); FSM never leaves IDLE.

## Test plan
- Reset held 2 cycles, released → `out_valid`=0, `result`=0, flags 0, `in_ready`=1 the cycle after release.
- ADD 0xFFFFFFFF+0x00000001 → result 0, zero=1, carry=1, ovf=0; ADD 0x7FFFFFFF+1 → 0x80000000, neg=1, ovf=1, carry=0.
- SUB 5−7 → 0xFFFFFFFE, carry=0, neg=1; SLT 0xFFFFFFFF vs 1 → 1; SLTU same → 0; SRA 0x80000000 by 4 → 0xF8000000.
- MUL (EN defined) 0x00012345 × 0x00000100 → 0x01234500, `in_ready`=0 for 32 cycles, `out_valid` exactly 32 cycles after acceptance; without EN → 0 after 1 cycle.
- Backpressure: `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0, result stable; raise `out_ready` → back-to-back results, one per cycle, none lost or duplicated.
- Reset asserted mid-MUL (cycle 10 of BUSY) → no `out_valid`, IDLE and `in_ready`=1 after release.
